// File: rtl/soc_event_queue_mc.sv
// Multi-channel event queue: saturating per-channel pending counters feed a
// round-robin arbiter and a registered valid/ready output stage.
module soc_event_queue_mc #(
    parameter int NB_CH      = 8,
    parameter int QUEUE_SIZE = 2,
    localparam int CNT_W     = $clog2(QUEUE_SIZE + 1),
    localparam int ID_W      = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [NB_CH-1:0] event_i,
    output logic             event_valid_o,
    output logic [ID_W-1:0]  event_id_o,
    input  logic             event_ready_i,
    output logic [NB_CH-1:0] err_o,
    output logic [NB_CH-1:0] pending_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUEUE_SIZE);
    localparam logic [ID_W:0]    NB_CH_W = (ID_W + 1)'(NB_CH);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NB_CH - 1);

    logic [CNT_W-1:0] cnt_r     [NB_CH];
    logic [CNT_W-1:0] cnt_nxt_s [NB_CH];
    logic [ID_W-1:0]  rr_r;
    logic [ID_W-1:0]  rr_nxt_s;
    logic [ID_W-1:0]  id_r;
    logic [ID_W-1:0]  grant_id_s;
    logic             grant_found_s;
    logic             load_s;
    logic [NB_CH-1:0] pending_s;
    logic [NB_CH-1:0] dec_s;
    logic [NB_CH-1:0] inc_s;
    logic [NB_CH-1:0] drop_s;
    out_state_e       state_r;
    out_state_e       state_nxt_s;

    // Pending flags come straight from the registered counters
    always_comb begin
        for (int c = 0; c < NB_CH; c++) begin
            pending_s[c] = (cnt_r[c] != {CNT_W{1'b0}});
        end
    end

    // Round-robin search: first pending channel at or after rr, wrapping
    always_comb begin
        logic [ID_W:0] idx_v;
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        idx_v         = {(ID_W + 1){1'b0}};
        for (int i = 0; i < NB_CH; i++) begin
            idx_v = {1'b0, rr_r} + (ID_W + 1)'(i);
            if (idx_v >= NB_CH_W) begin
                idx_v = idx_v - NB_CH_W;
            end else begin
                idx_v = idx_v;
            end
            if (!grant_found_s && pending_s[idx_v[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = idx_v[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign load_s = ((state_r == ST_EMPTY) || event_ready_i) && grant_found_s;

    // Counter update; a pop in the same cycle makes room for an event at full
    always_comb begin
        for (int c = 0; c < NB_CH; c++) begin
            dec_s[c]  = load_s && (grant_id_s == ID_W'(c));
            drop_s[c] = event_i[c] && (cnt_r[c] == CNT_MAX) && !dec_s[c];
            inc_s[c]  = event_i[c] && !drop_s[c];
            case ({inc_s[c], dec_s[c]})
                2'b10:   cnt_nxt_s[c] = cnt_r[c] + CNT_W'(1);
                2'b01:   cnt_nxt_s[c] = cnt_r[c] - CNT_W'(1);
                default: cnt_nxt_s[c] = cnt_r[c];
            endcase
        end
    end

    // Output-stage next state and round-robin pointer advance
    always_comb begin
        state_nxt_s = state_r;
        rr_nxt_s    = rr_r;
        case (state_r)
            ST_EMPTY: begin
                if (load_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (event_ready_i && !load_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
        if (load_s) begin
            rr_nxt_s = (grant_id_s == LAST_ID) ? {ID_W{1'b0}} : (grant_id_s + ID_W'(1));
        end else begin
            rr_nxt_s = rr_r;
        end
    end

    // State, pointer, output register and counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_EMPTY;
            rr_r    <= {ID_W{1'b0}};
            id_r    <= {ID_W{1'b0}};
            for (int c = 0; c < NB_CH; c++) begin
                cnt_r[c] <= {CNT_W{1'b0}};
            end
        end else begin
            state_r <= state_nxt_s;
            rr_r    <= rr_nxt_s;
            if (load_s) begin
                id_r <= grant_id_s;
            end
            for (int c = 0; c < NB_CH; c++) begin
                cnt_r[c] <= cnt_nxt_s[c];
            end
        end
    end

    assign event_valid_o = (state_r == ST_FULL);
    assign event_id_o    = id_r;
    assign pending_o     = pending_s;
    assign err_o         = drop_s;

endmodule

// File: tb/tb_soc_event_queue_mc.sv
// Directed and random bench for soc_event_queue_mc with a behavioural
// reference model feeding an ID scoreboard.
module tb_soc_event_queue_mc;

    localparam int NB  = 8;
    localparam int QS  = 2;
    localparam int IDW = 3;

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic [NB-1:0]  event_i;
    logic           event_valid_o;
    logic [IDW-1:0] event_id_o;
    logic           event_ready_i;
    logic [NB-1:0]  err_o;
    logic [NB-1:0]  pending_o;

    int total = 0;
    int bad   = 0;

    int       m_cnt [NB];
    logic     m_valid;
    int       m_id;
    int       m_rr;
    int       exp_q[$];
    int       hs_ids[$];
    int       hs_count;
    int       emit_cnt  [NB];
    int       pulse_cnt [NB];
    int       drop_cnt  [NB];
    logic [NB-1:0] last_err;
    logic     prev_hold;
    int       prev_id;
    int       rr_exp [6] = '{0, 2, 7, 0, 2, 7};

    soc_event_queue_mc #(
        .NB_CH      (NB),
        .QUEUE_SIZE (QS)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .event_i       (event_i),
        .event_valid_o (event_valid_o),
        .event_id_o    (event_id_o),
        .event_ready_i (event_ready_i),
        .err_o         (err_o),
        .pending_o     (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NB; c++) m_cnt[c] = 0;
        m_valid   = 1'b0;
        m_id      = 0;
        m_rr      = 0;
        prev_hold = 1'b0;
        prev_id   = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, check against the model, then advance it
    task automatic tick(input logic [NB-1:0] ev, input logic rdy);
        int            grant;
        logic          found;
        logic          load;
        logic [NB-1:0] e_err;
        logic [NB-1:0] e_pend;
        event_i       = ev;
        event_ready_i = rdy;
        #1;
        found = 1'b0;
        grant = 0;
        for (int k = 0; k < NB; k++) begin
            if (!found && m_cnt[(m_rr + k) % NB] > 0) begin
                found = 1'b1;
                grant = (m_rr + k) % NB;
            end
        end
        load = (!m_valid || rdy) && found;
        for (int c = 0; c < NB; c++) begin
            e_pend[c] = (m_cnt[c] > 0);
            e_err[c]  = ev[c] && (m_cnt[c] == QS) && !(load && grant == c);
        end
        check("valid", 32'(event_valid_o), 32'(m_valid));
        if (m_valid) check("id", 32'(event_id_o), m_id);
        check("pending", 32'(pending_o), 32'(e_pend));
        check("err", 32'(err_o), 32'(e_err));
        if (prev_hold) begin
            check("hold_valid", 32'(event_valid_o), 1);
            check("hold_id", 32'(event_id_o), prev_id);
        end
        last_err = err_o;
        if (event_valid_o && rdy) begin
            hs_count++;
            hs_ids.push_back(int'(event_id_o));
            emit_cnt[event_id_o]++;
            if (exp_q.size() > 0) check("sb_id", 32'(event_id_o), exp_q.pop_front());
            else check("sb_underflow", 32'(exp_q.size()), 1);
        end
        prev_hold = event_valid_o && !rdy;
        prev_id   = int'(event_id_o);
        for (int c = 0; c < NB; c++) begin
            if (ev[c]) pulse_cnt[c]++;
            if (e_err[c]) drop_cnt[c]++;
            if (ev[c] && !e_err[c]) m_cnt[c]++;
            if (load && grant == c) m_cnt[c]--;
        end
        if (load) begin
            m_valid = 1'b1;
            m_id    = grant;
            exp_q.push_back(grant);
            m_rr    = (grant + 1) % NB;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rstn_i        = 1'b0;
        event_i       = '0;
        event_ready_i = 1'b0;
        hs_count      = 0;
        last_err      = '0;
        for (int c = 0; c < NB; c++) begin
            emit_cnt[c]  = 0;
            pulse_cnt[c] = 0;
            drop_cnt[c]  = 0;
        end
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", 32'(event_valid_o), 0);
        check("rst_id", 32'(event_id_o), 0);
        check("rst_pending", 32'(pending_o), 0);
        check("rst_err", 32'(err_o), 0);
        rstn_i = 1'b1;

        // single event latency on channel 5
        tick(8'h20, 1'b1);
        check("lat_c1_pending", 32'(pending_o), 32'h20);
        check("lat_c1_valid", 32'(event_valid_o), 0);
        tick(8'h00, 1'b1);
        check("lat_c2_valid", 32'(event_valid_o), 1);
        check("lat_c2_id", 32'(event_id_o), 5);
        tick(8'h00, 1'b1);
        check("lat_c3_valid", 32'(event_valid_o), 0);
        check("lat_c3_pending", 32'(pending_o), 0);

        // saturation on channel 3 with no consumer
        tick(8'h08, 1'b0);
        check("sat_err1", 32'(last_err), 0);
        tick(8'h08, 1'b0);
        check("sat_err2", 32'(last_err), 0);
        tick(8'h08, 1'b0);
        check("sat_err3", 32'(last_err), 0);
        tick(8'h08, 1'b0);
        check("sat_err4", 32'(last_err), 32'h08);
        check("sat_valid", 32'(event_valid_o), 1);
        check("sat_id", 32'(event_id_o), 3);

        // push and pop at full: no drop, no bubble
        tick(8'h08, 1'b1);
        check("pp_err", 32'(last_err), 0);
        check("pp_valid", 32'(event_valid_o), 1);
        check("pp_id", 32'(event_id_o), 3);
        check("pp_pending", 32'(pending_o), 32'h08);
        hs_count = 0;
        repeat (6) tick(8'h00, 1'b1);
        check("pp_drain_count", hs_count, 3);
        check("pp_drain_valid", 32'(event_valid_o), 0);

        // reset mid-operation
        tick(8'h0E, 1'b0);
        tick(8'h0E, 1'b0);
        check("pre_rst_valid", 32'(event_valid_o), 1);
        check("pre_rst_id", 32'(event_id_o), 1);
        check("pre_rst_pending", 32'(pending_o), 32'h0E);
        event_i       = '0;
        event_ready_i = 1'b0;
        rstn_i        = 1'b0;
        #1;
        check("mid_rst_valid", 32'(event_valid_o), 0);
        check("mid_rst_id", 32'(event_id_o), 0);
        check("mid_rst_pending", 32'(pending_o), 0);
        check("mid_rst_err", 32'(err_o), 0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        model_reset();
        hs_count = 0;
        repeat (4) tick(8'h00, 1'b1);
        check("post_rst_hs", hs_count, 0);
        check("post_rst_valid", 32'(event_valid_o), 0);

        // round robin over channels 0, 2, 7
        tick(8'h85, 1'b0);
        tick(8'h85, 1'b0);
        hs_ids.delete();
        repeat (6) tick(8'h00, 1'b1);
        check("rr_count", 32'(hs_ids.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < hs_ids.size()) check("rr_order", hs_ids[i], rr_exp[i]);
        end
        check("rr_valid_end", 32'(event_valid_o), 0);

        // random traffic with back-pressure
        for (int c = 0; c < NB; c++) begin
            emit_cnt[c]  = 0;
            pulse_cnt[c] = 0;
            drop_cnt[c]  = 0;
        end
        repeat (400) tick(NB'($urandom & $urandom), 1'($urandom_range(0, 1)));
        repeat (30) tick(8'h00, 1'b1);
        for (int c = 0; c < NB; c++) begin
            check("rand_emit", emit_cnt[c], pulse_cnt[c] - drop_cnt[c]);
        end
        check("rand_sb_left", 32'(exp_q.size()), 0);
        check("rand_valid_end", 32'(event_valid_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
